pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch and program-counter stage directly upstream of the instruction decoder in the 16-bit single-cycle-style CPU.
- Holds the PC and fetches a 16-bit instruction word from instruction memory over a req/ack handshake.
- Presents the word as `ir` to the decoder and holds it stable until the datapath signals completion.
- Computes the next PC from the decoder's PL/JB/BC controls, the Z/N status flags and the register bus A.

Parameters:
- AW, 16, PC and instruction-address width in bits.
- PC_RESET, 0, PC value loaded on reset.
- TIMEOUT, 15, maximum cycles without `imem_ack` after a request before a fetch error is raised (legal range 1..255).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; enables starting new fetches.
- imem_addr  output  AW  instruction address; equals `pc` combinationally.
- imem_req  output  1  fetch request; held high until ack or timeout.
- imem_rdata  input  16  instruction word; valid when `imem_ack`=1.
- imem_ack  input  1  single-cycle memory acknowledge.
- ir  output  16  instruction register, drives the decoder.
- ir_valid  output  1  `ir` holds an instruction awaiting execution.
- exec_done  input  1  pulse from the datapath: the current instruction has completed.
- pl  input  1  decoder PC-load control.
- jb  input  1  decoder jump/branch select (1 = jump).
- bc  input  1  decoder branch condition (0 = branch on Z, 1 = branch on N).
- flag_z  input  1  zero flag from the function unit.
- flag_n  input  1  negative flag from the function unit.
- bus_a  input  16  register-file A bus; supplies the jump target.
- pc  output  AW  current PC.
- fetch_err  output  1  sticky timeout error.

Behaviour:
- Reset (async, `rst_n`=0):
  - `pc`=PC_RESET; `imem_req`=0; `ir`=0; `ir_valid`=0; `fetch_err`=0.
  - Timeout counter=0; state=IDLE.
  - Reset takes effect in any state, including mid-fetch or mid-execute. No pending request survives reset.
- State machine: IDLE, FETCH, EXEC, ERR.
- IDLE: `imem_req`=0, `ir_valid`=0. If `run`=1 at a clock edge, go to FETCH.
- FETCH:
  - `imem_req`=1 for every cycle in this state; the counter increments each cycle without ack.
  - On a cycle with `imem_ack`=1: latch `ir`<=`imem_rdata`, set `ir_valid`<=1, clear the counter, go to EXEC. `imem_req` is low the next cycle.
  - Ack latency is 0..TIMEOUT-1 cycles after entering FETCH. An ack in the first FETCH cycle is legal, giving a 1-cycle fetch.
  - If the counter reaches TIMEOUT with no ack: `fetch_err`<=1, `imem_req`<=0, go to ERR. An ack in that same cycle wins over the timeout.
- EXEC:
  - `ir` and `ir_valid` held stable; `imem_req`=0.
  - Waits indefinitely for `exec_done`; `pl`/`jb`/`bc` and the flags are sampled on the `exec_done` cycle.
  - Next PC, with AD = sign-extend({ir[8:6], ir[2:0]}) to AW bits:
    - `pl`=1, `jb`=1: pc <= bus_a[AW-1:0] (jump).
    - `pl`=1, `jb`=0, condition true: pc <= pc + AD. Condition is `flag_z` when `bc`=0, `flag_n` when `bc`=1.
    - Otherwise: pc <= pc + 1.
  - All PC arithmetic is modulo 2^AW (wrap-around, no flag).
  - On `exec_done`: `ir_valid`<=0; go to FETCH if `run`=1, else IDLE. `ir` retains its last value.
- ERR: terminal until reset. `imem_req`=0, `ir_valid`=0, `pc` frozen, `fetch_err`=1.
- `run` deasserted during FETCH or EXEC does not abort; the current instruction completes, then the unit goes to IDLE.
- `exec_done` outside EXEC and `imem_ack` outside FETCH are ignored.
- Throughput: minimum 2 cycles per instruction (1-cycle fetch, then `exec_done` in the first EXEC cycle).

Test Plan:
- Reset/sequential:
  - Stimulus: `rst_n` low, release with `run`=1; memory acks after 1 cycle with words 0x0000, 0x0001, 0x0002; `exec_done` one cycle after each `ir_valid`.
  - Required: `imem_addr` sequence 0,1,2; `ir` matches each word; `fetch_err`=0.
- Jump:
  - Stimulus: `pc`=0x0010; `pl`=1, `jb`=1, `bus_a`=0x1234 at `exec_done`.
  - Required: next `imem_addr`=0x1234.
- Branches:
  - Stimulus 1: `pc`=0x0005, `ir`=0xC1C6 (AD=-2), `pl`=1, `jb`=0, `bc`=0, `flag_z`=1. Required: next `pc`=0x0003.
  - Stimulus 2: same instruction with `bc`=1, `flag_n`=0. Required: next `pc`=0x0006.
- Wrap:
  - Stimulus: `pc`=0xFFFF, non-control instruction (`pl`=0).
  - Required: next `pc`=0x0000.
- Timeout:
  - Stimulus: `imem_ack` never asserted.
  - Required: after 15 request cycles, `fetch_err`=1 and `imem_req`=0. The unit stays in ERR despite later acks until `rst_n` pulses low, which clears `fetch_err` and reloads `pc`=0.
- Zero-latency ack and run drop:
  - Stimulus: ack in the same cycle as `imem_req` rises; drop `run` during EXEC.
  - Required: `ir_valid` rises one cycle after `imem_req`; after `exec_done` the unit enters IDLE with `imem_req`=0 and `pc` advanced by 1.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: fetches a word over a req/ack
// handshake, holds it for the decoder, then computes the next PC on exec_done.
module pc_fetch_unit #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] PC_RESET = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic [15:0]   imem_rdata,
  input  logic          imem_ack,
  output logic [15:0]   ir,
  output logic          ir_valid,
  input  logic          exec_done,
  input  logic          pl,
  input  logic          jb,
  input  logic          bc,
  input  logic          flag_z,
  input  logic          flag_n,
  input  logic [15:0]   bus_a,
  output logic [AW-1:0] pc,
  output logic          fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [15:0]   ir_q;
  logic          ir_valid_q;
  logic          req_q;
  logic          err_q;
  logic [7:0]    cnt_q;

  logic [5:0]    ad_raw;
  logic [AW-1:0] ad;
  logic          cond;

  assign ad_raw = {ir_q[8:6], ir_q[2:0]};
  assign ad     = {{(AW-6){ad_raw[5]}}, ad_raw};
  assign cond   = bc ? flag_n : flag_z;

  // NOTE: pc_d gets a default before any branch so no latch is inferred.
  always_comb begin
    pc_d = pc_q + AW'(1);
    if (pl) begin
      if (jb)        pc_d = bus_a[AW-1:0];
      else if (cond) pc_d = pc_q + ad;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        FETCH: begin
          // An ack in the final allowed cycle takes priority over the timeout.
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            state_q    <= EXEC;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ERR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        EXEC: begin
          if (exec_done) begin
            pc_q       <= pc_d;
            ir_valid_q <= 1'b0;
            if (run) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        ERR:     state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = req_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, jump, branches, wrap,
// timeout/error recovery, zero-latency ack and run drop.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] ir;
  logic        ir_valid;
  logic        exec_done;
  logic        pl, jb, bc, flag_z, flag_n;
  logic [15:0] bus_a;
  logic [15:0] pc;
  logic        fetch_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.AW(16), .PC_RESET(16'h0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done),
    .pl(pl), .jb(jb), .bc(bc), .flag_z(flag_z), .flag_n(flag_n),
    .bus_a(bus_a), .pc(pc), .fetch_err(fetch_err)
  );

  // Waits for imem_req, checks the address, acks after lat cycles, then
  // checks the instruction is presented with req dropped.
  task automatic fetch(input int lat, input logic [15:0] word,
                       input logic [15:0] exp_addr, input string name);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL %s addr: req=%b addr=%h, required req=1 addr=%h",
               name, imem_req, imem_addr, exp_addr);
    end
    repeat (lat) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'hDEAD;
    vectors++;
    if (ir !== word || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ir: ir=%h valid=%b req=%b, required ir=%h valid=1 req=0",
               name, ir, ir_valid, imem_req, word);
    end
  endtask

  task automatic execute(input logic p, input logic j, input logic b,
                         input logic z, input logic n, input logic [15:0] a,
                         input logic [15:0] exp_pc, input string name);
    exec_done = 1'b1;
    pl = p; jb = j; bc = b; flag_z = z; flag_n = n; bus_a = a;
    @(negedge clk);
    exec_done = 1'b0;
    pl = 0; jb = 0; bc = 0; flag_z = 0; flag_n = 0; bus_a = 16'h0;
    vectors++;
    if (pc !== exp_pc || ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pc: pc=%h valid=%b, required pc=%h valid=0",
               name, pc, ir_valid, exp_pc);
    end
  endtask

  task automatic test_reset_sequential();
    rst_n = 1'b0;
    #3;
    vectors++;
    if (pc !== 16'h0 || imem_req !== 1'b0 || ir !== 16'h0 ||
        ir_valid !== 1'b0 || fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: pc=%h req=%b ir=%h valid=%b err=%b, required all 0",
               pc, imem_req, ir, ir_valid, fetch_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fetch(1, 16'(k), 16'(k), "seq");
      execute(0, 0, 0, 0, 0, 16'h0, 16'(k + 1), "seq");
    end
    vectors++;
    if (fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_err: fetch_err=%b, required 0", fetch_err);
    end
  endtask

  task automatic test_jump();
    fetch(1, 16'hE000, 16'h0003, "jmp_pre");
    execute(1, 1, 0, 0, 0, 16'h0010, 16'h0010, "jmp_to_10");
    fetch(0, 16'hE001, 16'h0010, "jmp_at_10");
    execute(1, 1, 0, 0, 0, 16'h1234, 16'h1234, "jmp_1234");
    fetch(1, 16'hE002, 16'h1234, "jmp_target");
    execute(1, 1, 0, 0, 0, 16'h0005, 16'h0005, "jmp_to_5");
  endtask

  task automatic test_branches();
    fetch(2, 16'hC1C6, 16'h0005, "br_z");
    execute(1, 0, 0, 1, 0, 16'hFFFF, 16'h0003, "br_z_taken");
    fetch(1, 16'h0000, 16'h0003, "br_pre");
    execute(1, 1, 0, 0, 0, 16'h0005, 16'h0005, "br_back_to_5");
    fetch(1, 16'hC1C6, 16'h0005, "br_n");
    execute(1, 0, 1, 1, 0, 16'hFFFF, 16'h0006, "br_n_not_taken");
    fetch(1, 16'h0003, 16'h0006, "br_fwd");
    execute(1, 0, 1, 0, 1, 16'h0000, 16'h0009, "br_n_fwd_taken");
  endtask

  task automatic test_wrap();
    fetch(1, 16'h0000, 16'h0009, "wrap_pre");
    execute(1, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, "wrap_jmp");
    fetch(3, 16'h1111, 16'hFFFF, "wrap_at_ffff");
    execute(0, 1, 0, 1, 1, 16'h5555, 16'h0000, "wrap_inc");
  endtask

  task automatic test_zero_latency_run_drop();
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zl_req: req=%b valid=%b, required req=1 valid=0",
               imem_req, ir_valid);
    end
    fetch(0, 16'h2222, 16'h0000, "zl");
    run = 1'b0;
    @(negedge clk);
    execute(0, 0, 0, 0, 0, 16'h0, 16'h0001, "drop_inc");
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: req=%b, required 0", imem_req);
    end
    exec_done = 1'b1; pl = 1; jb = 1; bus_a = 16'h7777; imem_ack = 1'b1;
    @(negedge clk);
    exec_done = 1'b0; pl = 0; jb = 0; bus_a = 16'h0; imem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (pc !== 16'h0001 || imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 16'h2222) begin
      miscompares++;
      $display("FAIL idle_ignore: pc=%h req=%b valid=%b ir=%h, required pc=0001 req=0 valid=0 ir=2222",
               pc, imem_req, ir_valid, ir);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    run = 1'b1;
    @(negedge clk);
    while (imem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      @(negedge clk);
    end
    vectors++;
    if (req_cycles != 15 || fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: req_cycles=%0d err=%b req=%b, required 15 err=1 req=0",
               req_cycles, fetch_err, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 16'h3333;
    @(negedge clk);
    imem_ack = 1'b0;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b0 || pc !== 16'h0001) begin
      miscompares++;
      $display("FAIL err_sticky: err=%b req=%b valid=%b pc=%h, required err=1 req=0 valid=0 pc=0001",
               fetch_err, imem_req, ir_valid, pc);
    end
    rst_n = 1'b0;
    #2;
    vectors++;
    if (fetch_err !== 1'b0 || pc !== 16'h0000 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL err_reset: err=%b pc=%h req=%b, required err=0 pc=0000 req=0",
               fetch_err, pc, imem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetch(14, 16'h4444, 16'h0000, "late_ack");
    vectors++;
    if (fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack_err: err=%b, required 0", fetch_err);
    end
    execute(0, 0, 0, 0, 0, 16'h0, 16'h0001, "late_ack_exec");
  endtask

  initial begin
    run = 1'b0; imem_rdata = 16'h0; imem_ack = 1'b0; exec_done = 1'b0;
    pl = 0; jb = 0; bc = 0; flag_z = 0; flag_n = 0; bus_a = 16'h0;
    test_reset_sequential();
    test_jump();
    test_branches();
    test_wrap();
    test_zero_latency_run_drop();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
